mem_bist_ctrl: RTL and testbench

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

---
 rtl/mem_bist_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_bist_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_ctrl.sv
// March-free BIST controller: writes seed^address to every RAM word, reads the
// whole array back, and reports pass, mismatch count and first failing address.
module mem_bist_ctrl #(
    parameter int Data_width = 32,
    parameter int Addr_width = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [Data_width-1:0] seed,
    output logic                  mem_we,
    output logic [Addr_width-1:0] mem_address,
    output logic [Data_width-1:0] mem_d,
    input  logic [Data_width-1:0] mem_q,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [Addr_width:0]   err_count,
    output logic [Addr_width-1:0] fail_addr
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [Addr_width-1:0] LastAddr = '1;

    state_t                  state_q;
    logic [Addr_width-1:0]   addr_q;
    logic [Data_width-1:0]   seed_q;
    logic                    rd_valid_q;
    logic [Addr_width-1:0]   rd_addr_q;
    logic [Addr_width:0]     err_q;
    logic [Addr_width-1:0]   fail_q;
    logic                    pass_q;
    logic                    we_q;
    logic [Data_width-1:0]   d_q;
    logic                    busy_q;
    logic                    done_q;

    logic [Addr_width-1:0]   addr_inc_d;
    logic                    mismatch_d;
    logic [Addr_width:0]     err_d;

    function automatic logic [Data_width-1:0] pattern(input logic [Data_width-1:0] s,
                                                      input logic [Addr_width-1:0] a);
        return s ^ Data_width'(a);
    endfunction

    // The RAM returns data one cycle after the address, so the compare uses the
    // address copy captured alongside the read-valid flag.
    always_comb begin
        addr_inc_d = addr_q + Addr_width'(1);
        mismatch_d = rd_valid_q && (mem_q != pattern(seed_q, rd_addr_q));
        err_d      = err_q + (Addr_width+1)'(mismatch_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            seed_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            err_q      <= '0;
            fail_q     <= '0;
            pass_q     <= 1'b0;
            we_q       <= 1'b0;
            d_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (mismatch_d) begin
                err_q <= err_d;
                if (err_q == '0) begin
                    fail_q <= rd_addr_q;
                end
            end

            // Outputs are registered, so each branch loads the values for the
            // state being entered rather than the state being left.
            case (state_q)
                IDLE: begin
                    if (start) begin
                        seed_q  <= seed;
                        err_q   <= '0;
                        fail_q  <= '0;
                        addr_q  <= '0;
                        we_q    <= 1'b1;
                        d_q     <= pattern(seed, '0);
                        busy_q  <= 1'b1;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (addr_q == LastAddr) begin
                        addr_q  <= '0;
                        we_q    <= 1'b0;
                        d_q     <= '0;
                        state_q <= READ;
                    end else begin
                        addr_q <= addr_inc_d;
                        d_q    <= pattern(seed_q, addr_inc_d);
                    end
                end
                READ: begin
                    rd_valid_q <= 1'b1;
                    rd_addr_q  <= addr_q;
                    if (addr_q == LastAddr) begin
                        addr_q  <= '0;
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_inc_d;
                    end
                end
                DRAIN: begin
                    rd_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    pass_q     <= (err_d == '0);
                    state_q    <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_we      = we_q;
    assign mem_address = addr_q;
    assign mem_d       = d_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_count   = err_q;
    assign fail_addr   = fail_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Randomised scoreboard bench for mem_bist_ctrl with a fault-injecting RAM model;
// expected run results come from a whole-array reference computation.
module tb_mem_bist_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int DEPTH = 128;
    localparam int RUNLEN = 2*DEPTH + 2;

    typedef struct {
        int          startIdx;
        logic [31:0] seedVal;
        logic        passV;
        logic [7:0]  errV;
        logic [6:0]  failV;
    } expT;

    logic          clk;
    logic          reset;
    logic          start;
    logic [DW-1:0] seed;
    logic          memWe;
    logic [AW-1:0] memAddress;
    logic [DW-1:0] memD;
    logic [DW-1:0] memQ;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   errCount;
    logic [AW-1:0] failAddr;

    int  checks   = 0;
    int  failures = 0;
    int  negCount = 0;
    expT expQ[$];
    expT lastExp;
    logic haveLast;

    logic [31:0] ram [DEPTH];
    logic [31:0] qRaw;
    logic [6:0]  qAddr;
    logic [31:0] stuckMask;
    logic [31:0] corruptMask [DEPTH];

    mem_bist_ctrl #(.Data_width(DW), .Addr_width(AW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .seed(seed),
        .mem_we(memWe),
        .mem_address(memAddress),
        .mem_d(memD),
        .mem_q(memQ),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(errCount),
        .fail_addr(failAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with registered read; faults are applied on the read path.
    always @(posedge clk) begin
        if (memWe) ram[memAddress] <= memD;
        qRaw  <= ram[memAddress];
        qAddr <= memAddress;
    end
    assign memQ = (qRaw | stuckMask) ^ corruptMask[qAddr];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Whole-array prediction: every word should read back as seed^address.
    function automatic expT predict(input logic [31:0] s, input int idx);
        expT e;
        int  errs = 0;
        e.startIdx = idx;
        e.seedVal  = s;
        e.failV    = '0;
        for (int a = 0; a < DEPTH; a++) begin
            logic [31:0] stored;
            logic [31:0] readBack;
            stored   = s ^ 32'(a);
            readBack = (stored | stuckMask) ^ corruptMask[a];
            if (readBack != stored) begin
                if (errs == 0) e.failV = 7'(a);
                errs++;
            end
        end
        e.errV  = 8'(errs);
        e.passV = (errs == 0);
        return e;
    endfunction

    task automatic clearFaults();
        stuckMask = '0;
        for (int a = 0; a < DEPTH; a++) corruptMask[a] = '0;
    endtask

    task automatic clearLast();
        lastExp.passV = 1'b0;
        lastExp.errV  = '0;
        lastExp.failV = '0;
        haveLast      = 1'b1;
    endtask

    // Called just after a rising edge with the DUT idle; the next edge accepts.
    task automatic applyStimulus(input logic [31:0] s, input int runs);
        int base;
        base = negCount + 1;
        for (int k = 0; k < runs; k++) expQ.push_back(predict(s, base + k*(RUNLEN+1)));
        seed  = s;
        start = 1'b1;
        if (runs == 1) begin
            @(posedge clk); #2;
            start = 1'b0;
            seed  = $urandom;
        end
    endtask

    task automatic waitIdle(input int budget);
        int c = 0;
        while (expQ.size() != 0 && c < budget) begin
            @(posedge clk); #2;
            c++;
        end
        checkOutput("runCompletes", 64'(expQ.size()), 64'(0));
        expQ.delete();
        start = 1'b0;
    endtask

    // Monitor: per-cycle protocol check against the run timeline, results on done.
    always @(negedge clk) begin
        int          n;
        logic        expBusy, expDone, expWe;
        logic [6:0]  expAddr;
        logic [31:0] expD;
        negCount++;
        if (!reset) begin
            if (expQ.size() == 0) begin
                checkOutput("idleOutputs", 64'({busy, done, memWe, memAddress, memD}), 64'(0));
                if (haveLast)
                    checkOutput("heldResults", 64'({pass, errCount, failAddr}),
                                64'({lastExp.passV, lastExp.errV, lastExp.failV}));
            end else begin
                n       = negCount - expQ[0].startIdx;
                expBusy = (n >= 1) && (n <= RUNLEN - 1);
                expDone = (n == RUNLEN);
                expWe   = (n >= 1) && (n <= DEPTH);
                expAddr = expWe ? 7'(n - 1) : ((n > DEPTH) && (n <= 2*DEPTH)) ? 7'(n - DEPTH - 1) : 7'd0;
                expD    = expWe ? (expQ[0].seedVal ^ 32'(n - 1)) : 32'd0;
                checkOutput("cycleOutputs", 64'({busy, done, memWe, memAddress, memD}),
                            64'({expBusy, expDone, expWe, expAddr, expD}));
                if (n == RUNLEN) begin
                    checkOutput("runResults", 64'({pass, errCount, failAddr}),
                                64'({expQ[0].passV, expQ[0].errV, expQ[0].failV}));
                    lastExp  = expQ[0];
                    haveLast = 1'b1;
                    void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nCor;
        reset    = 1'b1;
        start    = 1'b0;
        seed     = '0;
        haveLast = 1'b0;
        clearFaults();
        repeat (3) @(posedge clk); #2;
        checkOutput("resetOutputs",
                    64'({busy, done, pass, memWe, memAddress, memD, errCount, failAddr}), 64'(0));
        reset = 1'b0;
        clearLast();
        repeat (3) @(posedge clk); #2;

        $display("[TB] ideal RAM run");
        applyStimulus(32'hA5A5_0000, 1);
        waitIdle(400);
        checkOutput("idealPass", 64'({pass, errCount}), 64'({1'b1, 8'd0}));

        $display("[TB] bit 3 stuck at one");
        stuckMask = 32'h0000_0008;
        applyStimulus(32'h0, 1);
        waitIdle(400);
        checkOutput("stuckResults", 64'({pass, errCount, failAddr}), 64'({1'b0, 8'd64, 7'h00}));
        clearFaults();

        $display("[TB] single corrupted word");
        corruptMask[7'h55] = 32'h0000_0100;
        applyStimulus($urandom, 1);
        waitIdle(400);
        checkOutput("singleResults", 64'({pass, errCount, failAddr}), 64'({1'b0, 8'd1, 7'h55}));
        clearFaults();

        $display("[TB] start pulse during a run");
        applyStimulus($urandom, 1);
        repeat (49) @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        waitIdle(400);
        repeat (5) @(posedge clk); #2;

        $display("[TB] reset in the middle of READ");
        corruptMask[7'h05] = 32'h0000_0001;
        applyStimulus($urandom, 1);
        repeat (160) @(posedge clk); #2;
        checkOutput("preResetState", 64'({busy, memWe, memAddress, errCount}),
                    64'({1'b1, 1'b0, 7'h20, 8'd1}));
        reset = 1'b1;
        #1;
        checkOutput("asyncReset",
                    64'({busy, done, pass, memWe, memAddress, memD, errCount, failAddr}), 64'(0));
        expQ.delete();
        clearLast();
        repeat (2) @(posedge clk); #2;
        reset = 1'b0;
        clearFaults();
        repeat (20) @(posedge clk); #2;
        checkOutput("stayIdle", 64'({busy, memWe}), 64'(0));
        applyStimulus($urandom, 1);
        waitIdle(400);

        $display("[TB] start held high, back-to-back runs");
        applyStimulus(32'hFFFF_FFFF, 3);
        waitIdle(3 * 300);
        repeat (5) @(posedge clk); #2;

        $display("[TB] every word corrupted");
        for (int a = 0; a < DEPTH; a++) corruptMask[a] = 32'h8000_0000;
        applyStimulus($urandom, 1);
        waitIdle(400);
        checkOutput("fullErrCount", 64'({pass, errCount, failAddr}), 64'({1'b0, 8'd128, 7'h00}));
        clearFaults();

        $display("[TB] randomised fault runs");
        for (int r = 0; r < 4; r++) begin
            clearFaults();
            if ($urandom_range(0, 1) == 1) stuckMask = 32'h1 << $urandom_range(0, 31);
            nCor = $urandom_range(0, 6);
            for (int j = 0; j < nCor; j++) corruptMask[$urandom_range(0, DEPTH-1)] = $urandom | 32'h1;
            applyStimulus($urandom, 1);
            waitIdle(400);
        end
        clearFaults();
        repeat (5) @(posedge clk); #2;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
